host_task_enq_fifo: RTL and testbench

- Buffers host-injected tasks between the OCL control-port slave and the tile's task unit.
- The slave presents one task_t per OCL_TASK_ENQ write. This block accepts it into a small FIFO and releases it to the task unit under a valid/ready handshake, so host enqueues never stall on task-unit back-pressure until the FIFO is full.
- It is a reg-bus component with its own ID, which exposes occupancy, traffic counters, pause and flush controls.

---
 rtl/chronos_pkg.sv | 29 ++
 rtl/sync_fifo_fwft.sv | 66 ++++++
 rtl/host_task_enq_fifo.sv | 125 ++++++++++++
 tb/tb_host_task_enq_fifo.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chronos_pkg.sv
// rtl/chronos_pkg.sv - shared tile types, component IDs and host-enqueue register offsets
package chronos;

    typedef logic [31:0] reg_data_t;

    typedef struct packed {
        logic [31:0] ts;
        logic [31:0] object;
        logic [3:0]  ttype;
    } task_t;

    typedef enum logic [3:0] {
        ID_SPLITTER,
        ID_TASK_UNIT,
        ID_CQ,
        ID_OCL_SLAVE,
        ID_HOST_ENQ,
        ID_LAST
    } component_id_t;

    localparam logic [7:0] HEF_OCCUPANCY  = 8'h00;
    localparam logic [7:0] HEF_ENQ_CNT    = 8'h04;
    localparam logic [7:0] HEF_DEQ_CNT    = 8'h08;
    localparam logic [7:0] HEF_STALL_CNT  = 8'h0C;
    localparam logic [7:0] HEF_HIGH_WATER = 8'h10;
    localparam logic [7:0] HEF_CTRL       = 8'h14;
    localparam logic [7:0] HEF_DEPTH      = 8'h18;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with synchronous flush
module sync_fifo_fwft #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic [LOG_DEPTH:0]   count_o,
    output logic [LOG_DEPTH:0]   count_next_o
);

    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);
    localparam logic [LOG_DEPTH:0]   CNT_ONE = (LOG_DEPTH + 1)'(1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o      = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/host_task_enq_fifo.sv
// rtl/host_task_enq_fifo.sv - host task enqueue buffer with reg-bus counters, pause and flush
module host_task_enq_fifo
    import chronos::*;
#(
    parameter int            LOG_DEPTH = 4,
    parameter component_id_t REG_ID    = ID_HOST_ENQ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  task_t       in_data,
    output logic        in_ready,
    output logic        out_valid,
    output task_t       out_data,
    input  logic        out_ready,
    input  logic        reg_wvalid,
    input  logic [7:0]  reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_arvalid,
    input  logic [7:0]  reg_araddr,
    output logic        reg_rvalid,
    output reg_data_t   reg_rdata
);

    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH + 1)'(DEPTH);

    logic [LOG_DEPTH:0] count, count_next;
    logic        flush_now, push, pop;
    logic        wr_stall, wr_hw, wr_ctrl;
    logic [31:0] count_ext, count_next_ext;
    logic [31:0] enq_cnt_q, enq_cnt_d;
    logic [31:0] deq_cnt_q, deq_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] high_water_q, high_water_d;
    logic        pause_q, pause_d;
    logic        rvalid_q;
    reg_data_t   rdata_q, rdata_mux;
    logic        unused_ok;

    assign wr_ctrl   = reg_wvalid && (reg_waddr == HEF_CTRL);
    assign wr_stall  = reg_wvalid && (reg_waddr == HEF_STALL_CNT);
    assign wr_hw     = reg_wvalid && (reg_waddr == HEF_HIGH_WATER);
    assign flush_now = wr_ctrl && reg_wdata[1];

    assign in_ready  = (count != DEPTH_C) && !flush_now && !rst;
    assign out_valid = (count != '0) && !pause_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    sync_fifo_fwft #(
        .WIDTH     ($bits(task_t)),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_now),
        .push_i       (push),
        .pop_i        (pop),
        .wdata_i      (in_data),
        .rdata_o      (out_data),
        .count_o      (count),
        .count_next_o (count_next)
    );

    assign count_ext      = 32'(count);
    assign count_next_ext = 32'(count_next);

    // Software clears take priority over a same-cycle increment.
    always_comb begin
        enq_cnt_d    = enq_cnt_q + 32'(push);
        deq_cnt_d    = deq_cnt_q + 32'(pop);
        stall_cnt_d  = stall_cnt_q + 32'(in_valid && !in_ready);
        high_water_d = high_water_q;
        pause_d      = pause_q;
        if (wr_stall) stall_cnt_d = '0;
        if (wr_hw) begin
            high_water_d = count_ext;
        end else if (count_next_ext > high_water_q) begin
            high_water_d = count_next_ext;
        end
        if (wr_ctrl) pause_d = reg_wdata[0];
    end

    always_comb begin
        rdata_mux = '0;
        case (reg_araddr)
            HEF_OCCUPANCY:  rdata_mux = count_ext;
            HEF_ENQ_CNT:    rdata_mux = enq_cnt_q;
            HEF_DEQ_CNT:    rdata_mux = deq_cnt_q;
            HEF_STALL_CNT:  rdata_mux = stall_cnt_q;
            HEF_HIGH_WATER: rdata_mux = high_water_q;
            HEF_CTRL:       rdata_mux = {31'b0, pause_q};
            HEF_DEPTH:      rdata_mux = 32'(DEPTH);
            default:        rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enq_cnt_q    <= '0;
            deq_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            high_water_q <= '0;
            pause_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            enq_cnt_q    <= enq_cnt_d;
            deq_cnt_q    <= deq_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            high_water_q <= high_water_d;
            pause_q      <= pause_d;
            rvalid_q     <= reg_arvalid;
            if (reg_arvalid) rdata_q <= rdata_mux;
        end
    end

    assign reg_rvalid = rvalid_q;
    assign reg_rdata  = rdata_q;

    // REG_ID is routed by the parent; upper write-data bits carry no meaning here.
    assign unused_ok = ^{REG_ID, reg_wdata[31:2]};

endmodule

// File: tb/tb_host_task_enq_fifo.sv
// tb/tb_host_task_enq_fifo.sv - directed self-checking bench for host_task_enq_fifo
module tb_host_task_enq_fifo;
    import chronos::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    task_t       in_data;
    logic        in_ready;
    logic        out_valid;
    task_t       out_data;
    logic        out_ready;
    logic        reg_wvalid;
    logic [7:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_arvalid;
    logic [7:0]  reg_araddr;
    logic        reg_rvalid;
    reg_data_t   reg_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    host_task_enq_fifo #(.LOG_DEPTH(4), .REG_ID(ID_HOST_ENQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .reg_wvalid  (reg_wvalid),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .reg_arvalid (reg_arvalid),
        .reg_araddr  (reg_araddr),
        .reg_rvalid  (reg_rvalid),
        .reg_rdata   (reg_rdata)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ts;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_ts;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    vec_t    vecs[5];
    rd_vec_t post_rst[6];
    logic [31:0] drain_ts[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_task(input logic [31:0] ts);
        in_data        = '0;
        in_data.ts     = ts;
        in_data.object = ~ts;
        in_data.ttype  = ts[3:0];
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
        reg_arvalid = 1'b1;
        reg_araddr  = addr;
        tick();
        reg_arvalid = 1'b0;
        #1;
        check({name, "_rvalid"}, 32'(reg_rvalid), 32'd1);
        check(name, reg_rdata, exp);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
        reg_wvalid = 1'b1;
        reg_waddr  = addr;
        reg_wdata  = data;
        tick();
        reg_wvalid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{iv: 1'b1, ts: 32'd10, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_ts: 32'd0};
        vecs[1] = '{iv: 1'b1, ts: 32'd11, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b1, exp_ts: 32'd10};
        vecs[2] = '{iv: 1'b1, ts: 32'd12, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b1, exp_ts: 32'd11};
        vecs[3] = '{iv: 1'b0, ts: 32'd0,  ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b1, exp_ts: 32'd12};
        vecs[4] = '{iv: 1'b0, ts: 32'd0,  ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_ts: 32'd0};

        post_rst[0] = '{addr: HEF_OCCUPANCY,  exp: 32'd0};
        post_rst[1] = '{addr: HEF_ENQ_CNT,    exp: 32'd0};
        post_rst[2] = '{addr: HEF_DEQ_CNT,    exp: 32'd0};
        post_rst[3] = '{addr: HEF_STALL_CNT,  exp: 32'd0};
        post_rst[4] = '{addr: HEF_HIGH_WATER, exp: 32'd0};
        post_rst[5] = '{addr: HEF_CTRL,       exp: 32'd0};

        drain_ts[0] = 32'd113; drain_ts[1] = 32'd114; drain_ts[2] = 32'd115;
        drain_ts[3] = 32'd116; drain_ts[4] = 32'd200; drain_ts[5] = 32'd201;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        reg_wvalid = 1'b0; reg_waddr = '0; reg_wdata = '0;
        reg_arvalid = 1'b0; reg_araddr = '0;
        set_task(32'd0);
        #1;
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rvalid", 32'(reg_rvalid), 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: FWFT latency and order
        for (int i = 0; i < 5; i++) begin
            in_valid  = vecs[i].iv;
            set_task(vecs[i].ts);
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("s1_in_ready[%0d]", i), 32'(in_ready), 32'(vecs[i].exp_ir));
            check($sformatf("s1_out_valid[%0d]", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov)
                check($sformatf("s1_out_ts[%0d]", i), out_data.ts, vecs[i].exp_ts);
            tick();
        end
        out_ready = 1'b0;
        do_read(HEF_ENQ_CNT, 32'd3, "s1_enq_cnt");
        do_read(HEF_DEQ_CNT, 32'd3, "s1_deq_cnt");
        do_read(HEF_OCCUPANCY, 32'd0, "s1_occupancy");

        // 2: fill to 16 then stall
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            set_task(32'(100 + i));
            #1;
            check($sformatf("s2_accept[%0d]", i), 32'(in_ready), 32'd1);
            tick();
        end
        set_task(32'd116);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("s2_full[%0d]", i), 32'(in_ready), 32'd0);
            tick();
        end
        do_read(HEF_STALL_CNT, 32'd5, "s2_stall_cnt");
        do_read(HEF_OCCUPANCY, 32'd16, "s2_occupancy");
        do_read(HEF_HIGH_WATER, 32'd16, "s2_high_water");

        // 3: one pop at full, push lands the following cycle
        out_ready = 1'b1;
        #1;
        check("s3_pop_valid", 32'(out_valid), 32'd1);
        check("s3_pop_ts", out_data.ts, 32'd100);
        check("s3_no_push_at_full", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        #1;
        check("s3_push_after_pop", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        do_read(HEF_OCCUPANCY, 32'd16, "s3_occupancy");
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("s3_drain_valid[%0d]", i), 32'(out_valid), 32'd1);
            check($sformatf("s3_drain_ts[%0d]", i), out_data.ts, 32'(101 + i));
            tick();
        end
        out_ready = 1'b0;

        // 4: pause holds head, pushes still accepted
        do_write(HEF_CTRL, 32'h1);
        out_ready = 1'b1;
        #1;
        check("s4_paused_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            set_task(32'(200 + i));
            #1;
            check($sformatf("s4_paused_accept[%0d]", i), 32'(in_ready), 32'd1);
            check($sformatf("s4_paused_ov[%0d]", i), 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        do_read(HEF_CTRL, 32'd1, "s4_ctrl");
        do_write(HEF_CTRL, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("s4_drain_valid[%0d]", i), 32'(out_valid), 32'd1);
            check($sformatf("s4_drain_ts[%0d]", i), out_data.ts, drain_ts[i]);
            tick();
        end
        #1;
        check("s4_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        do_read(HEF_ENQ_CNT, 32'd22, "s4_enq_cnt");
        do_read(HEF_DEQ_CNT, 32'd22, "s4_deq_cnt");

        // 5: flush with a push pending
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            set_task(32'(300 + i));
            tick();
        end
        set_task(32'd305);
        reg_wvalid = 1'b1;
        reg_waddr  = HEF_CTRL;
        reg_wdata  = 32'h2;
        #1;
        check("s5_flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        reg_wvalid = 1'b0;
        in_valid   = 1'b0;
        #1;
        check("s5_flush_out_valid", 32'(out_valid), 32'd0);
        do_read(HEF_OCCUPANCY, 32'd0, "s5_occupancy");
        do_read(HEF_ENQ_CNT, 32'd27, "s5_enq_cnt");
        do_read(HEF_CTRL, 32'd0, "s5_ctrl");
        do_read(HEF_HIGH_WATER, 32'd16, "s5_high_water");
        do_write(HEF_HIGH_WATER, 32'hDEAD);
        do_read(HEF_HIGH_WATER, 32'd0, "s5_hw_cleared");
        do_write(HEF_STALL_CNT, 32'h0);
        do_read(HEF_STALL_CNT, 32'd0, "s5_stall_cleared");

        // 6: depth, unmapped, reset mid-queue
        do_read(HEF_DEPTH, 32'd16, "s6_depth");
        do_read(8'h40, 32'd0, "s6_unmapped");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_task(32'(400 + i));
            tick();
        end
        in_valid    = 1'b0;
        rst         = 1'b1;
        reg_arvalid = 1'b1;
        reg_araddr  = HEF_ENQ_CNT;
        #1;
        check("s6_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst         = 1'b0;
        reg_arvalid = 1'b0;
        #1;
        check("s6_rvalid_suppressed", 32'(reg_rvalid), 32'd0);
        check("s6_rst_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++)
            do_read(post_rst[i].addr, post_rst[i].exp, $sformatf("s6_post_rst[%0d]", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
